// File: rtl/synth_pkg.sv
// Shared types and default widths for the oscillator blocks.
package synth_pkg;

    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GLIDE
    } nco_state_t;

endpackage

// File: rtl/nco_glide_slew.sv
// Computes the next increment for an exponential glide toward the target tuning word.
module nco_glide_slew
    import synth_pkg::*;
#(
    parameter int ACC_W       = synth_pkg::ACC_W,
    parameter int GLIDE_SHIFT = 6
) (
    input  logic [ACC_W-1:0] inc,
    input  logic [ACC_W-1:0] target,
    output logic [ACC_W-1:0] inc_next
);

    logic signed [ACC_W:0] diff;
    logic signed [ACC_W:0] step;

    // The extra sign bit keeps the full unsigned range. A step of zero snaps to target.
    // Because the step is a shifted copy of diff, it can never exceed diff, so the
    // increment cannot overshoot the target.
    always_comb begin
        diff     = $signed({1'b0, target}) - $signed({1'b0, inc});
        step     = diff >>> GLIDE_SHIFT;
        inc_next = (step == '0) ? target : inc + step[ACC_W-1:0];
    end

endmodule

// File: rtl/saw_phase_acc.sv
// Phase-accumulator NCO: sawtooth phase word, glide, hard sync and wrap pulse.
module saw_phase_acc
    import synth_pkg::*;
#(
    parameter int ACC_W       = synth_pkg::ACC_W,
    parameter int OUT_W       = synth_pkg::OUT_W,
    parameter int GLIDE_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             tick,
    input  logic             sync,
    input  logic             glide_en,
    input  logic [ACC_W-1:0] ftw,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    output logic [OUT_W-1:0] saw,
    output logic             wrap
);

    nco_state_t       state, state_next;
    logic [ACC_W-1:0] acc, inc, target, inc_next;
    logic [ACC_W:0]   sum;
    logic             active, accept;

    nco_glide_slew #(
        .ACC_W      (ACC_W),
        .GLIDE_SHIFT(GLIDE_SHIFT)
    ) u_slew (
        .inc     (inc),
        .target  (target),
        .inc_next(inc_next)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ftw_ready  = 1'b0;
        active     = locked && (state != IDLE);
        sum        = {1'b0, acc} + {1'b0, inc};
        case (state)
            IDLE:  state_next = (inc == target) ? RUN : GLIDE;
            RUN:   ftw_ready  = locked;
            GLIDE: if (tick && inc_next == target) state_next = RUN;
            default: state_next = IDLE;
        endcase
        accept = ftw_valid && ftw_ready;
        if (accept && glide_en && ftw != inc) state_next = GLIDE;
        if (!locked) state_next = IDLE;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // the accumulator therefore always sees the increment from before this edge's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            inc    <= '0;
            target <= '0;
            saw    <= '0;
            wrap   <= 1'b0;
        end else begin
            state <= state_next;
            wrap  <= 1'b0;
            if (accept) begin
                target <= ftw;
                if (!glide_en) inc <= ftw;
            end
            if (active && tick) begin
                if (state == GLIDE) inc <= inc_next;
                if (sync) begin
                    acc <= '0;
                    saw <= '0;
                end else begin
                    acc  <= sum[ACC_W-1:0];
                    saw  <= sum[ACC_W-1 -: OUT_W];
                    wrap <= sum[ACC_W];
                end
            end
        end
    end

endmodule
